// File: rtl/flit_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : flit_assembler
//  Description : NoC ejection-side reassembly of 4-flit packets per source,
//                queueing completed 68-bit packets in a valid/ready FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_assembler #(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int QUEUE_DEPTH     = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    ce,
    input  logic [1+2*$clog2(NODE_COUNT)+17+PACKET_ID_WIDTH+2-1:0]  flit_in,
    input  logic                                                    flit_valid,
    output logic [67:0]                                             pkt_out,
    output logic [$clog2(NODE_COUNT)-1:0]                           pkt_src,
    output logic [PACKET_ID_WIDTH-1:0]                              pkt_id,
    output logic                                                    pkt_valid,
    input  logic                                                    pkt_ready,
    output logic                                                    seq_err,
    output logic                                                    ovf_err
);

    localparam int c_nw             = $clog2(NODE_COUNT);
    localparam int c_pw             = PACKET_ID_WIDTH;
    localparam int c_aw             = $clog2(QUEUE_DEPTH);
    localparam int c_ew             = 68 + c_nw + c_pw;
    localparam int c_pid_lo         = 2 + c_nw;
    localparam int c_pay_lo         = c_pid_lo + c_pw;
    localparam int c_dst_lo         = c_pay_lo + 17;
    localparam int c_vb             = c_dst_lo + c_nw;
    localparam int c_unused_node_id = NODE_ID;

    // Flit field extraction: {vbit, dest, payload, pid, src, idx}
    logic [1:0]      w_idx;
    logic [c_nw-1:0] w_src;
    logic [c_pw-1:0] w_pid;
    logic [16:0]     w_pay;
    logic            w_vbit;
    logic            w_unused_dest;

    assign w_idx         = flit_in[1:0];
    assign w_src         = flit_in[c_pid_lo-1:2];
    assign w_pid         = flit_in[c_pay_lo-1:c_pid_lo];
    assign w_pay         = flit_in[c_dst_lo-1:c_pay_lo];
    assign w_vbit        = flit_in[c_vb];
    assign w_unused_dest = ^flit_in[c_vb-1:c_dst_lo];

    // Per-source reassembly slots
    logic [NODE_COUNT-1:0] r_busy;
    logic [1:0]            r_exp [NODE_COUNT];
    logic [c_pw-1:0]       r_pid [NODE_COUNT];
    logic [50:0]           r_acc [NODE_COUNT];

    logic w_accept;
    logic w_slot_busy;
    logic w_match;
    logic w_start;
    logic w_advance;
    logic w_complete;
    logic w_drop;
    logic w_seq;

    assign w_accept    = ce & flit_valid & w_vbit;
    assign w_slot_busy = r_busy[w_src];
    assign w_match     = w_slot_busy && (w_idx == r_exp[w_src]) && (w_pid == r_pid[w_src]);
    assign w_start     = w_accept && (w_idx == 2'd0);
    assign w_advance   = w_accept && (w_idx != 2'd0) && w_match;
    assign w_complete  = w_advance && (w_idx == 2'd3);
    assign w_drop      = w_accept && (w_idx != 2'd0) && !w_match;
    assign w_seq       = (w_start && w_slot_busy) || w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < NODE_COUNT; i++) begin
                r_exp[i] <= 2'd0;
                r_pid[i] <= '0;
                r_acc[i] <= '0;
            end
        end else if (w_start) begin
            // A new idx0 always restarts the slot, discarding any partial packet
            r_busy[w_src]        <= 1'b1;
            r_exp[w_src]         <= 2'd1;
            r_pid[w_src]         <= w_pid;
            r_acc[w_src][50:34]  <= w_pay;
        end else if (w_advance) begin
            r_exp[w_src] <= w_idx + 2'd1;
            if (w_idx == 2'd1) r_acc[w_src][33:17] <= w_pay;
            if (w_idx == 2'd2) r_acc[w_src][16:0]  <= w_pay;
            if (w_complete)    r_busy[w_src]       <= 1'b0;
        end else if (w_drop) begin
            r_busy[w_src] <= 1'b0;
        end
    end

    // Completed-packet FIFO
    logic [c_ew-1:0] r_mem [QUEUE_DEPTH];
    logic [c_aw-1:0] r_wr;
    logic [c_aw-1:0] r_rd;
    logic [c_aw:0]   r_count;
    logic [c_ew-1:0] r_last;
    logic [c_ew-1:0] w_entry;
    logic [c_ew-1:0] w_head;
    logic            w_nonempty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == (c_aw+1)'(QUEUE_DEPTH));
    assign w_pop      = ce & w_nonempty & pkt_ready;
    assign w_push     = w_complete & (~w_full | w_pop);
    assign w_ovf      = w_complete & w_full & ~w_pop;
    assign w_entry    = {r_acc[w_src], w_pay, w_src, w_pid};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + c_aw'(1);
            if (w_pop) begin
                r_rd   <= r_rd + c_aw'(1);
                r_last <= r_mem[r_rd];
            end
            if (w_push && !w_pop)      r_count <= r_count + (c_aw+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (c_aw+1)'(1);
        end
    end

    // Once drained, the outputs keep showing the last popped entry
    assign w_head    = w_nonempty ? r_mem[r_rd] : r_last;
    assign pkt_out   = w_head[c_ew-1:c_nw+c_pw];
    assign pkt_src   = w_head[c_nw+c_pw-1:c_pw];
    assign pkt_id    = w_head[c_pw-1:0];
    assign pkt_valid = w_nonempty;

    logic r_seq_err;
    logic r_ovf_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_seq_err <= w_seq;
            r_ovf_err <= w_ovf;
        end
    end

    assign seq_err = r_seq_err;
    assign ovf_err = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_flit_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flit_assembler
//  Description : Self-checking bench for flit_assembler with a queue-based
//                reference model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_assembler;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [30:0] flit_in;
    logic        flit_valid;
    logic [67:0] pkt_out;
    logic [2:0]  pkt_src;
    logic [4:0]  pkt_id;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        seq_err;
    logic        ovf_err;

    flit_assembler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .pkt_out    (pkt_out),
        .pkt_src    (pkt_src),
        .pkt_id     (pkt_id),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    // Stimulus fields, packed into flit_in just before each edge
    logic        t_v;
    logic [2:0]  t_dest;
    logic [2:0]  t_src;
    logic [16:0] t_pay;
    logic [4:0]  t_pid;
    logic [1:0]  t_idx;

    // Reference model: per-source payload arrays and a queue of finished packets
    bit          m_busy [8];
    int          m_next [8];
    logic [4:0]  m_pid  [8];
    logic [16:0] m_pay  [8][4];
    logic [75:0] m_q [$];
    bit          e_seq;
    bit          e_ovf;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_busy[i] = 1'b0;
            m_next[i] = 0;
            m_pid[i]  = '0;
        end
        m_q.delete();
        e_seq = 1'b0;
        e_ovf = 1'b0;
    endtask

    task automatic step();
        bit          pop;
        bit          push;
        logic [75:0] ent;
        logic [75:0] head;
        int          s;
        flit_in = {t_v, t_dest, t_pay, t_pid, t_src, t_idx};
        e_seq = 1'b0;
        e_ovf = 1'b0;
        push  = 1'b0;
        ent   = '0;
        pop   = ce && (m_q.size() > 0) && pkt_ready;
        s     = int'(t_src);
        if (ce && flit_valid && t_v) begin
            if (t_idx == 2'd0) begin
                if (m_busy[s]) e_seq = 1'b1;
                m_busy[s]   = 1'b1;
                m_pid[s]    = t_pid;
                m_pay[s][0] = t_pay;
                m_next[s]   = 1;
            end else if (m_busy[s] && int'(t_idx) == m_next[s] && t_pid == m_pid[s]) begin
                m_pay[s][t_idx] = t_pay;
                if (t_idx == 2'd3) begin
                    push      = 1'b1;
                    ent       = {m_pay[s][0], m_pay[s][1], m_pay[s][2], t_pay, t_src, t_pid};
                    m_busy[s] = 1'b0;
                end else begin
                    m_next[s] = m_next[s] + 1;
                end
            end else begin
                e_seq     = 1'b1;
                m_busy[s] = 1'b0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ent);
            else e_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check("pkt_valid", pkt_valid, m_q.size() > 0);
        check("seq_err", seq_err, e_seq);
        check("ovf_err", ovf_err, e_ovf);
        if (m_q.size() > 0) begin
            head = m_q[0];
            check("pkt_out", pkt_out, head[75:8]);
            check("pkt_src", pkt_src, head[7:5]);
            check("pkt_id", pkt_id, head[4:0]);
        end
    endtask

    task automatic send(input int src, input int pid, input int idx, input logic [16:0] pay);
        flit_valid = 1'b1;
        t_v    = 1'b1;
        t_dest = 3'($urandom);
        t_src  = 3'(src);
        t_pid  = 5'(pid);
        t_idx  = 2'(idx);
        t_pay  = pay;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            flit_valid = 1'b0;
            t_v = 1'($urandom);
            step();
        end
    endtask

    task automatic full_pkt(input int src, input int pid);
        for (int k = 0; k < 4; k++) send(src, pid, k, 17'($urandom));
    endtask

    initial begin
        int occ;
        int s;
        rst_n = 1'b0; ce = 1'b1; flit_valid = 1'b0; pkt_ready = 1'b0;
        t_v = 1'b0; t_dest = '0; t_src = '0; t_pay = '0; t_pid = '0; t_idx = '0;
        flit_in = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_out", pkt_out, 68'h0);
        check("rst_src", pkt_src, 3'h0);
        check("rst_id", pkt_id, 5'h0);
        check("rst_seq", seq_err, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        rst_n = 1'b1;

        // Single packet, immediate pop
        pkt_ready = 1'b1;
        send(2, 5, 0, 17'h1ABCD);
        send(2, 5, 1, 17'h00001);
        send(2, 5, 2, 17'h10000);
        send(2, 5, 3, 17'h0F0F0);
        check("t1_valid", pkt_valid, 1'b1);
        check("t1_out", pkt_out, {17'h1ABCD, 17'h00001, 17'h10000, 17'h0F0F0});
        check("t1_src", pkt_src, 3'd2);
        check("t1_id", pkt_id, 5'd5);
        idle(1);
        check("t1_empty", pkt_valid, 1'b0);

        // Interleaved sources, src 6 finishes first
        pkt_ready = 1'b0;
        send(1, 3, 0, 17'h11111); send(6, 7, 0, 17'h06060);
        send(1, 3, 1, 17'h12222); send(6, 7, 1, 17'h16161);
        send(1, 3, 2, 17'h13333); send(6, 7, 2, 17'h06262);
        send(6, 7, 3, 17'h16363); send(1, 3, 3, 17'h14444);
        check("t2_first", pkt_src, 3'd6);
        pkt_ready = 1'b1;
        idle(1);
        check("t2_second", pkt_src, 3'd1);
        check("t2_second_out", pkt_out, {17'h11111, 17'h12222, 17'h13333, 17'h14444});
        idle(1);

        // Out-of-order index
        send(4, 9, 0, 17'($urandom));
        send(4, 9, 2, 17'($urandom));
        check("t3_skip", seq_err, 1'b1);
        send(4, 9, 3, 17'($urandom));
        check("t3_idle3", seq_err, 1'b1);
        full_pkt(4, 10);
        check("t3_fresh", pkt_src, 3'd4);
        idle(2);

        // pid mismatch
        send(3, 1, 0, 17'($urandom));
        send(3, 2, 1, 17'($urandom));
        check("t4_pid", seq_err, 1'b1);
        idle(1);
        check("t4_none", pkt_valid, 1'b0);

        // Overflow on the ninth packet, then drain in order
        pkt_ready = 1'b0;
        for (int p = 0; p < 9; p++) full_pkt(0, p);
        check("t5_ovf", ovf_err, 1'b1);
        idle(1);
        check("t5_ovf_pulse", ovf_err, 1'b0);
        pkt_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            check("t5_order", pkt_id, 5'(p));
            idle(1);
        end
        check("t5_drained", pkt_valid, 1'b0);

        // Push into a full queue on the same edge as a pop
        pkt_ready = 1'b0;
        for (int p = 0; p < 8; p++) full_pkt(0, p);
        send(0, 20, 0, 17'($urandom));
        send(0, 20, 1, 17'($urandom));
        send(0, 20, 2, 17'($urandom));
        pkt_ready = 1'b1;
        send(0, 20, 3, 17'($urandom));
        check("t6_no_ovf", ovf_err, 1'b0);
        occ = 0;
        for (int i = 0; i < 12; i++) begin
            if (pkt_valid) begin
                occ++;
                idle(1);
            end
        end
        check("t6_occupancy", occ, 8);

        // Asynchronous reset in the middle of a packet with data queued
        pkt_ready = 1'b0;
        full_pkt(1, 2);
        send(5, 3, 0, 17'($urandom));
        send(5, 3, 1, 17'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", pkt_valid, 1'b0);
        check("t6_rst_out", pkt_out, 68'h0);
        check("t6_rst_src", pkt_src, 3'h0);
        check("t6_rst_id", pkt_id, 5'h0);
        check("t6_rst_seq", seq_err, 1'b0);
        model_clear();
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        full_pkt(5, 3);
        check("t6_after_rst", pkt_src, 3'd5);
        idle(2);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            ce         = ($urandom_range(0, 9) != 0);
            pkt_ready  = ($urandom_range(0, 2) != 0);
            flit_valid = ($urandom_range(0, 3) != 0);
            t_v        = ($urandom_range(0, 9) != 0);
            t_src      = 3'($urandom_range(0, 7));
            t_dest     = 3'($urandom);
            t_pay      = 17'($urandom);
            s          = int'(t_src);
            if ($urandom_range(0, 9) < 8) begin
                if (m_busy[s]) begin
                    t_idx = 2'(m_next[s]);
                    t_pid = m_pid[s];
                end else begin
                    t_idx = 2'd0;
                    t_pid = 5'($urandom);
                end
            end else begin
                t_idx = 2'($urandom);
                t_pid = 5'($urandom_range(0, 3));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flit_assembler.md
Name: flit_assembler

Overview:
- Receive-side counterpart of the packet splitter; sits at a node's NoC ejection port.
- Takes 4-flit packets (17 payload bits per flit) arriving from any source node, possibly interleaved between sources.
- Reassembles them per source into 68-bit packets and queues the completed packets in a FIFO.
- The FIFO feeds the core's receive logic over a valid/ready handshake.

Parameters:
- NODE_ID, 0, this node's index; informational only, no checks against the dest field.
- NODE_COUNT, 8, number of nodes; NW = $clog2(NODE_COUNT).
- PACKET_ID_WIDTH, 5, packet id width.
- QUEUE_DEPTH, 8, completed-packet FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; when low all state holds
- flit_in  in  1+2*NW+17+PACKET_ID_WIDTH+2  flit, MSB→LSB: {vbit, dest[NW], payload[17], pid, src[NW], idx[2]}
- flit_valid  in  1  flit_in qualifier
- pkt_out  out  68  reassembled packet
- pkt_src  out  NW  source node of pkt_out
- pkt_id  out  PACKET_ID_WIDTH  packet id of pkt_out
- pkt_valid  out  1  FIFO non-empty
- pkt_ready  in  1  consumer accepts head entry
- seq_err  out  1  one-cycle pulse: flit dropped or partial packet discarded
- ovf_err  out  1  one-cycle pulse: completed packet lost, FIFO full

Behaviour:
- Reset (rst_n low, async): all slots idle, FIFO empty. pkt_valid=0, pkt_out=0, pkt_src=0, pkt_id=0, seq_err=0, ovf_err=0.
- Reset mid-packet discards all partial and queued data.
- Flit accept: a flit is taken on a rising edge with ce=1 and flit_valid=1 and vbit=1. Any other cycle is ignored. dest is not checked.
- Per-source slots: one slot per source (NODE_COUNT slots). Each slot holds busy, exp_idx[2], pid, acc[50:0].
- Payload mapping: idx0 → packet[67:51], idx1 → [50:34], idx2 → [33:17], idx3 → [16:0].
- idx=0 on an idle slot: busy=1, store pid, store payload, exp_idx=1.
- idx=0 on a busy slot: pulse seq_err, discard the old partial, start the new packet as above.
- idx=k>0 with busy, k==exp_idx and pid match, k<3: store payload, exp_idx=k+1.
- idx=3 under the same conditions: push {acc, payload, src, pid} into the FIFO; slot returns idle.
- idx>0 with slot idle, idx≠exp_idx, or pid mismatch: drop the flit, slot goes idle, pulse seq_err.
- Push with FIFO full and no pop in the same cycle: packet lost, pulse ovf_err, slot still returns idle.
- Push with FIFO full and a pop in the same cycle: push succeeds.
- Latency: completing flit at edge t → pkt_valid=1 after edge t (visible in cycle t+1) when the FIFO was empty.
- FIFO output: pkt_out/pkt_src/pkt_id driven from the head entry. Pop on ce && pkt_valid && pkt_ready.
- Simultaneous push and pop: occupancy unchanged, both take effect.
- Pointers wrap modulo QUEUE_DEPTH. Occupancy counter is $clog2(QUEUE_DEPTH)+1 bits.
- Empty FIFO: pkt_valid=0, data outputs hold their last value (not required zero).
- seq_err and ovf_err are registered and assert in the cycle after the triggering edge. They can assert together.
- ce=0: no accept, no pop, error pulses deassert, all other state held.

Test Plan (NODE_COUNT=8, PACKET_ID_WIDTH=5, QUEUE_DEPTH=8):
1. src=2, pid=5, flits idx0..3 with payloads 0x1ABCD, 0x00001, 0x10000, 0x0F0F0 on consecutive cycles, pkt_ready=1 → one cycle after idx3, pkt_valid=1, pkt_out={0x1ABCD,0x00001,0x10000,0x0F0F0}, pkt_src=2, pkt_id=5; pop next edge, then pkt_valid=0.
2. Interleaved src=1 pid=3 and src=6 pid=7, alternating flits, src 6 completes first → FIFO order is src6 then src1, both payloads intact, seq_err never asserts.
3. src=4 flits idx0, idx2 → seq_err pulses once, idx2 dropped, slot idle. A following idx3 also pulses seq_err. A fresh 4-flit packet from src=4 then completes normally.
4. src=3 idx0 with pid=1, then idx1 with pid=2 → seq_err, slot idle, no packet queued.
5. pkt_ready=0, 9 complete packets from src=0, pids 0..8 → the ninth gives ovf_err for one cycle. Raise pkt_ready: pids 0..7 drain in order, then pkt_valid=0.
6. Queue at 8 entries, pkt_ready=1, and a completing flit on the same edge as a pop → no ovf_err, occupancy stays 8. Separately, assert rst_n low mid-packet → all outputs 0 immediately and the next packet assembles cleanly.
